// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter and sequencer: fetch (port 0) vs data (port 1), with ack timeout.
// Optional FAIR_RR_EN: round-robin tie-break between simultaneous requests.

module mem_port_arbiter_mux2 #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = sel ? b : a;
endmodule

// state | meaning
// IDLE  | no owner, waiting for a request
// BUSY  | owner holds the memory port, mem_req high, waiting for mem_ack
// RESP  | done pulse (and timeout_err if aborted) to the owner
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mux_sel,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          win;

`ifdef FAIR_RR_EN
    logic last_winner;

    // Ties go to whichever port did not win last; single requests win outright.
    always_comb begin
        win = req1;
        if (req0 && req1)
            win = ~last_winner;
    end
`else
    always_comb begin
        win = req1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mux_sel     <= 1'b0;
            mem_req     <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            timeout_err <= 1'b0;
            rdata       <= '0;
`ifdef FAIR_RR_EN
            last_winner <= 1'b0;
`endif
        end else begin
            done0       <= 1'b0;
            done1       <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        mux_sel <= win;
                        gnt0    <= ~win;
                        gnt1    <= win;
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        state   <= BUSY;
`ifdef FAIR_RR_EN
                        last_winner <= win;
`endif
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        rdata   <= mem_rdata;
                        mem_req <= 1'b0;
                        done0   <= gnt0;
                        done1   <= gnt1;
                        state   <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rdata       <= '0;
                        mem_req     <= 1'b0;
                        done0       <= gnt0;
                        done1       <= gnt1;
                        timeout_err <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_port_arbiter_mux2 #(.W(ADDR_WIDTH)) u_addr_mux (
        .sel (mux_sel),
        .a   (addr0),
        .b   (addr1),
        .y   (mem_addr)
    );

    assign mem_we    = mem_req & mux_sel & we1;
    assign mem_wdata = mux_sel ? wdata1 : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases then randomized requesters and memory.
module tb_mem_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we1 = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata1 = '0, mem_rdata = '0;
    logic          mux_sel, mem_req, mem_we, gnt0, gnt1, done0, done1, timeout_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rdata;

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the port, how long it has waited, whether it is responding.
    int            m_owner = -1;
    int            m_waited = 0;
    bit            m_resp = 0;
    bit            m_sel = 0, m_done0 = 0, m_done1 = 0, m_terr = 0, m_last = 0;
    logic [DW-1:0] m_rdata = '0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .req1(req1), .we1(we1),
        .addr1(addr1), .wdata1(wdata1), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mux_sel(mux_sel), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit busy;
        int w;
        busy = (m_owner >= 0) && !m_resp;
        m_done0 = 0;
        m_done1 = 0;
        m_terr  = 0;
        if (rst) begin
            m_owner = -1; m_waited = 0; m_resp = 0; m_sel = 0; m_last = 0; m_rdata = '0;
        end else if (m_resp) begin
            m_resp  = 0;
            m_owner = -1;
        end else if (busy) begin
            if (mem_ack) begin
                m_rdata = mem_rdata;
                m_resp  = 1;
            end else if (m_waited + 1 == TO) begin
                m_rdata = '0;
                m_resp  = 1;
                m_terr  = 1;
            end else begin
                m_waited++;
            end
            if (m_resp) begin
                m_done0 = (m_owner == 0);
                m_done1 = (m_owner == 1);
            end
        end else if (req0 || req1) begin
            w = req1 ? 1 : 0;
`ifdef FAIR_RR_EN
            if (req0 && req1) w = m_last ? 0 : 1;
`endif
            m_owner  = w;
            m_sel    = (w == 1);
            m_last   = (w == 1);
            m_waited = 0;
        end
    endtask

    task automatic compare_all();
        bit            e_req;
        logic [AW-1:0] e_addr;
        e_req  = (m_owner >= 0) && !m_resp;
        e_addr = m_sel ? addr1 : addr0;
        chk("mux_sel", mux_sel, m_sel);
        chk("mem_req", mem_req, e_req);
        chk("gnt0", gnt0, m_owner == 0);
        chk("gnt1", gnt1, m_owner == 1);
        chk("done0", done0, m_done0);
        chk("done1", done1, m_done1);
        chk("timeout_err", timeout_err, m_terr);
        chk("rdata", rdata, m_rdata);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", mem_we, e_req && m_sel && we1);
        chk("mem_wdata", mem_wdata, m_sel ? wdata1 : 8'h00);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    int  busy_cnt;
    int  done0_seen;
    bit  got_done;
    bit  pulse0 = 0, pulse1 = 0;
    int  ack_pct;

    initial begin
        // reset
        step();
        step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;

        // fetch only, ack on the 2nd BUSY cycle
        req0 = 1; addr0 = 8'h3C;
        step();
        chk("fetch_busy1_req", mem_req, 1);
        chk("fetch_addr", mem_addr, 8'h3C);
        chk("fetch_we", mem_we, 0);
        chk("fetch_sel", mux_sel, 0);
        step();
        chk("fetch_busy2_req", mem_req, 1);
        mem_ack = 1; mem_rdata = 8'hA5;
        step();
        chk("fetch_done0", done0, 1);
        chk("fetch_rdata", rdata, 8'hA5);
        chk("fetch_resp_req", mem_req, 0);
        req0 = 0; mem_ack = 0; mem_rdata = 8'h00;
        step();
        chk("fetch_idle_done0", done0, 0);
        chk("fetch_idle_rdata_held", rdata, 8'hA5);

        // store with ack present from the start (ignored in IDLE)
        req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'h7E; mem_ack = 1; mem_rdata = 8'h11;
        step();
        chk("store_we", mem_we, 1);
        chk("store_wdata", mem_wdata, 8'h7E);
        chk("store_sel", mux_sel, 1);
        chk("store_addr", mem_addr, 8'h10);
        step();
        chk("store_done1", done1, 1);
        chk("store_terr", timeout_err, 0);
        req1 = 0; we1 = 0; mem_ack = 0;
        step();

        // simultaneous requests: port 1 first, then port 0
        req0 = 1; req1 = 1; addr0 = 8'h20; addr1 = 8'h30;
        step();
        chk("tie1_gnt1", gnt1, 1);
        chk("tie1_addr", mem_addr, 8'h30);
        mem_ack = 1; mem_rdata = 8'h5A;
        step();
        chk("tie1_done1", done1, 1);
        req1 = 0; mem_ack = 0;
        step();
        step();
        chk("tie1_then_gnt0", gnt0, 1);
        chk("tie1_then_addr", mem_addr, 8'h20);
        mem_ack = 1; mem_rdata = 8'hC3;
        step();
        chk("tie1_done0", done0, 1);
        chk("tie1_rdata0", rdata, 8'hC3);
        req0 = 0; mem_ack = 0;
        step();
        req0 = 1; req1 = 1;
        step();
        chk("tie2_gnt1", gnt1, 1);
        mem_ack = 1;
        step();
        req1 = 0; req0 = 0; mem_ack = 0;
        step();
        step();

        // no ack: abort after exactly TO BUSY cycles
        req0 = 1; addr0 = 8'h55;
        busy_cnt = 0; got_done = 0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            step();
            if (mem_req) busy_cnt++;
            if (done0) begin
                got_done = 1;
                chk("to_terr", timeout_err, 1);
                chk("to_rdata", rdata, 8'h00);
                req0 = 0;
            end
        end
        chk("to_done_seen", got_done, 1);
        chk("to_busy_cycles", busy_cnt, 15);
        step();
        chk("to_idle_gnt", {gnt1, gnt0}, 0);
        chk("to_idle_req", mem_req, 0);

        // reset during the 2nd BUSY cycle
        req1 = 1; we1 = 0; addr1 = 8'h44;
        step();
        step();
        chk("rstmid_busy2", mem_req, 1);
        rst = 1;
        step();
        chk("rstmid_req", mem_req, 0);
        chk("rstmid_gnt1", gnt1, 0);
        chk("rstmid_done1", done1, 0);
        chk("rstmid_sel", mux_sel, 0);
        rst = 0; req1 = 0; mem_ack = 1; mem_rdata = 8'hEE;
        step();
        step();
        chk("rstmid_late_ack_done", {done1, done0}, 0);
        chk("rstmid_late_ack_rdata", rdata, 0);
        mem_ack = 0;

        // req0 pulse while port 1 owns the port
        req1 = 1; addr1 = 8'h66;
        step();
        chk("pulse_own1", gnt1, 1);
        req0 = 1; addr0 = 8'h77;
        step();
        req0 = 0;
        step();
        mem_ack = 1;
        step();
        chk("pulse_done1", done1, 1);
        req1 = 0; mem_ack = 0;
        done0_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done0 || gnt0) done0_seen++;
        end
        chk("pulse_no_port0", done0_seen, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit drop0, drop1;
            ack_pct = (i < 2000) ? 40 : 6;
            mem_ack   = ($urandom_range(99) < ack_pct);
            mem_rdata = 8'($urandom);
            rst       = ($urandom_range(299) == 0);
            drop0 = 0; drop1 = 0;
            if (req0 && (m_done0 || (pulse0 && m_owner != 0))) begin req0 = 0; drop0 = 1; end
            if (req1 && (m_done1 || (pulse1 && m_owner != 1))) begin req1 = 0; drop1 = 1; end
            if (m_owner == 0) pulse0 = 0;
            if (m_owner == 1) pulse1 = 0;
            if (!req0 && !drop0 && $urandom_range(3) == 0) begin
                req0 = 1; addr0 = 8'($urandom); pulse0 = ($urandom_range(7) == 0);
            end
            if (!req1 && !drop1 && $urandom_range(3) == 0) begin
                req1 = 1; addr1 = 8'($urandom); wdata1 = 8'($urandom); we1 = 1'($urandom);
                pulse1 = ($urandom_range(7) == 0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
